// File: rtl/hv_stream_sender.sv
// Streams a buffered list of hypervector words to a kernel, then waits for and captures its result.
// Optional WAIT_DONE watchdog enabled by defining HV_SENDER_TIMEOUT_EN.
module hv_stream_sender #(
   parameter int HV_DATA_WIDTH = 32,
   parameter int MAX_INPUTS    = 16,
   parameter int TIMEOUT_CLKS  = 1024,
   localparam int ADDR_WIDTH   = $clog2(MAX_INPUTS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [ADDR_WIDTH-1:0]    wr_addr,
   input  logic [HV_DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH:0]      num_inputs,
   input  logic                     start,
   input  logic                     k_ready,
   output logic                     k_valid,
   output logic                     k_first,
   output logic                     k_last,
   output logic [HV_DATA_WIDTH-1:0] k_data,
   input  logic                     k_done,
   input  logic [HV_DATA_WIDTH-1:0] k_result,
   output logic [HV_DATA_WIDTH-1:0] result,
   output logic                     busy,
   output logic                     complete,
   output logic                     error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_INPUTS);
   localparam logic [ADDR_WIDTH:0] ONE_CNT = (ADDR_WIDTH + 1)'(1);

   state_t                     state_reg;
   logic [ADDR_WIDTH:0]        count_reg;
   logic [ADDR_WIDTH:0]        idx_reg;
   logic                       k_valid_reg;
   logic                       k_first_reg;
   logic                       k_last_reg;
   logic [HV_DATA_WIDTH-1:0]   k_data_reg;
   logic [HV_DATA_WIDTH-1:0]   result_reg;
   logic                       complete_reg;
   logic                       error_reg;

   logic [HV_DATA_WIDTH-1:0]   buffer_mem [MAX_INPUTS];
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic [HV_DATA_WIDTH-1:0]   rd_word;
   logic                       idle;
   logic                       start_ok;
   logic                       xfer;

`ifdef HV_SENDER_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
   logic [TIMER_W-1:0]         timer_reg;
`endif

   assign idle     = (state_reg == ST_IDLE);
   assign start_ok = (num_inputs != '0) && (num_inputs <= MAX_CNT);
   assign xfer     = k_valid_reg && k_ready;

   always_ff @(posedge clk) begin
      if (wr_en && idle) begin
         buffer_mem[wr_addr] <= wr_data;
      end
   end

   // In IDLE the only word ever needed next is word 0; a same-cycle write is forwarded.
   always_comb begin
      rd_addr = idle ? '0 : idx_reg[ADDR_WIDTH-1:0];
      rd_word = buffer_mem[rd_addr];
      if (wr_en && idle && (wr_addr == rd_addr)) begin
         rd_word = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         count_reg    <= '0;
         idx_reg      <= '0;
         k_valid_reg  <= 1'b0;
         k_first_reg  <= 1'b0;
         k_last_reg   <= 1'b0;
         k_data_reg   <= '0;
         result_reg   <= '0;
         complete_reg <= 1'b0;
         error_reg    <= 1'b0;
`ifdef HV_SENDER_TIMEOUT_EN
         timer_reg    <= '0;
`endif
      end else begin
         complete_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     count_reg   <= num_inputs;
                     idx_reg     <= ONE_CNT;
                     error_reg   <= 1'b0;
                     k_valid_reg <= 1'b1;
                     k_first_reg <= 1'b1;
                     k_last_reg  <= (num_inputs == ONE_CNT);
                     k_data_reg  <= rd_word;
                     state_reg   <= ST_SEND;
                  end else begin
                     error_reg   <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  if (k_last_reg) begin
                     k_valid_reg <= 1'b0;
                     k_first_reg <= 1'b0;
                     k_last_reg  <= 1'b0;
                     state_reg   <= ST_WAIT_DONE;
`ifdef HV_SENDER_TIMEOUT_EN
                     timer_reg   <= '0;
`endif
                  end else begin
                     // idx_reg names the word being loaded now, so it is last when it equals count-1.
                     k_data_reg  <= rd_word;
                     k_first_reg <= 1'b0;
                     k_last_reg  <= (idx_reg == (count_reg - ONE_CNT));
                     idx_reg     <= idx_reg + ONE_CNT;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (k_done) begin
                  result_reg   <= k_result;
                  complete_reg <= 1'b1;
                  state_reg    <= ST_IDLE;
`ifdef HV_SENDER_TIMEOUT_EN
               end else if (timer_reg == TIMER_LAST) begin
                  error_reg    <= 1'b1;
                  state_reg    <= ST_IDLE;
               end else begin
                  timer_reg    <= timer_reg + 1'b1;
`endif
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign k_valid  = k_valid_reg;
   assign k_first  = k_first_reg;
   assign k_last   = k_last_reg;
   assign k_data   = k_data_reg;
   assign result   = result_reg;
   assign busy     = !idle;
   assign complete = complete_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_hv_stream_sender.sv
// Directed bench for hv_stream_sender: streams, backpressure, bad counts, mid-stream reset, WAIT_DONE watchdog.
module tb_hv_stream_sender;

   localparam int W  = 32;
   localparam int N  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [AW:0]   num_inputs;
   logic          start;
   logic          k_ready;
   logic          k_valid, k_first, k_last;
   logic [W-1:0]  k_data;
   logic          k_done;
   logic [W-1:0]  k_result;
   logic [W-1:0]  result;
   logic          busy, complete, error;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] q_data[$];
   logic         q_first[$];
   logic         q_last[$];
   int           q_cyc[$];
   int           cyc = 0;
   int           n_complete = 0;
   int           stab_err = 0;
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic         prev_first = 1'b0;
   logic         prev_last = 1'b0;
   logic [W-1:0] exp_w [4];
   logic [1:0]   ready_pat [6];
   int           c0;

   always #5 clk = ~clk;

   hv_stream_sender #(
      .HV_DATA_WIDTH(W),
      .MAX_INPUTS(N),
      .TIMEOUT_CLKS(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .num_inputs(num_inputs),
      .start(start),
      .k_ready(k_ready),
      .k_valid(k_valid),
      .k_first(k_first),
      .k_last(k_last),
      .k_data(k_data),
      .k_done(k_done),
      .k_result(k_result),
      .result(result),
      .busy(busy),
      .complete(complete),
      .error(error)
   );

   // Handshake monitor: inputs change just after posedge, so negedge sees what the next edge will use.
   always @(negedge clk) begin
      cyc++;
      if (hold_prev && (!k_valid || k_data !== prev_data || k_first !== prev_first || k_last !== prev_last))
         stab_err++;
      if (k_valid && k_ready) begin
         q_data.push_back(k_data);
         q_first.push_back(k_first);
         q_last.push_back(k_last);
         q_cyc.push_back(cyc);
      end
      if (complete) n_complete++;
      hold_prev  = k_valid && !k_ready && reset_n;
      prev_data  = k_data;
      prev_first = k_first;
      prev_last  = k_last;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int addr, input logic [W-1:0] data);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_first.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic start_stream(input int n);
      num_inputs = (AW + 1)'(n);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_stream(input int n);
      int i = 0;
      while (i < 40 && !(q_data.size() >= n && !k_valid)) begin
         tick();
         i++;
      end
      check("stream_wait", 64'(i < 40), 64'd1);
   endtask

   task automatic check_stream(input string tag, input int n);
      check({tag, "_count"}, 64'(q_data.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < q_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(exp_w[i]));
            check($sformatf("%s_first%0d", tag, i), 64'(q_first[i]), 64'(i == 0));
            check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == n - 1));
         end
      end
   endtask

   task automatic finish_kernel(input logic [W-1:0] value);
      k_done   = 1'b1;
      k_result = value;
      tick();
      k_done   = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_inputs = '0;
      start = 1'b0; k_ready = 1'b0; k_done = 1'b0; k_result = '0;
      tick(); tick();
      check("rst_k_valid", 64'(k_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_complete", 64'(complete), 64'd0);
      check("rst_k_data", 64'(k_data), 64'd0);
      reset_n = 1'b1;
      tick();

      // Four-word stream, back-to-back transfers
      for (int i = 0; i < 4; i++) write_word(i, W'(i + 1));
      exp_w[0] = 32'h1; exp_w[1] = 32'h2; exp_w[2] = 32'h3; exp_w[3] = 32'h4;
      clear_q();
      k_ready = 1'b1;
      start_stream(4);
      check("s4_first_valid", 64'(k_valid), 64'd1);
      check("s4_first_flag", 64'(k_first), 64'd1);
      check("s4_first_data", 64'(k_data), 64'h1);
      check("s4_busy", 64'(busy), 64'd1);
      wait_stream(4);
      check_stream("s4", 4);
      if (q_cyc.size() == 4) check("s4_b2b", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
      check("s4_wait_busy", 64'(busy), 64'd1);
      finish_kernel(32'hDEADBEEF);
      check("s4_result", 64'(result), 64'hDEADBEEF);
      check("s4_complete", 64'(complete), 64'd1);
      check("s4_idle", 64'(busy), 64'd0);
      tick();
      check("s4_complete_pulse", 64'(complete), 64'd0);
      check("s4_result_hold", 64'(result), 64'hDEADBEEF);

      // k_done in IDLE must not capture
      finish_kernel(32'h00000BAD);
      check("idle_kdone_result", 64'(result), 64'hDEADBEEF);
      check("idle_kdone_complete", 64'(complete), 64'd0);

      // Single-word stream
      write_word(0, 32'hA5A5A5A5);
      exp_w[0] = 32'hA5A5A5A5;
      clear_q();
      start_stream(1);
      check("s1_valid", 64'(k_valid), 64'd1);
      check("s1_first", 64'(k_first), 64'd1);
      check("s1_last", 64'(k_last), 64'd1);
      wait_stream(1);
      check_stream("s1", 1);
      finish_kernel(32'h12345678);
      check("s1_result", 64'(result), 64'h12345678);

      // Backpressure 1,0,0,1,0,1 with start/wr_en/k_done attempts while busy
      write_word(0, 32'h10); write_word(1, 32'h20); write_word(2, 32'h30);
      exp_w[0] = 32'h10; exp_w[1] = 32'h20; exp_w[2] = 32'h30;
      ready_pat[0] = 1; ready_pat[1] = 0; ready_pat[2] = 0;
      ready_pat[3] = 1; ready_pat[4] = 0; ready_pat[5] = 1;
      clear_q();
      c0 = n_complete;
      k_ready = 1'b0; k_done = 1'b1; k_result = 32'h00000BAD;
      start_stream(3);
      for (int i = 0; i < 6; i++) begin
         k_ready    = ready_pat[i][0];
         wr_en      = (i == 1);
         wr_addr    = 4'd2;
         wr_data    = 32'hFFFF;
         start      = (i == 1);
         num_inputs = 5'd2;
         tick();
      end
      k_ready = 1'b0; k_done = 1'b0; wr_en = 1'b0; start = 1'b0;
      check_stream("bp", 3);
      check("bp_stable", 64'(stab_err), 64'd0);
      check("bp_no_complete", 64'(n_complete - c0), 64'd0);
      check("bp_result_kept", 64'(result), 64'h12345678);
      check("bp_wait_busy", 64'(busy), 64'd1);
      finish_kernel(32'hCAFEF00D);
      check("bp_result", 64'(result), 64'hCAFEF00D);

      // Illegal counts, then a start with a simultaneous write to word 0
      clear_q();
      start_stream(0);
      check("n0_error", 64'(error), 64'd1);
      check("n0_busy", 64'(busy), 64'd0);
      check("n0_valid", 64'(k_valid), 64'd0);
      tick();
      start_stream(17);
      check("n17_error", 64'(error), 64'd1);
      check("n17_busy", 64'(busy), 64'd0);
      tick(); tick();
      check("n17_no_words", 64'(q_data.size()), 64'd0);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h77;
      start_stream(1);
      wr_en = 1'b0;
      check("restart_error_clr", 64'(error), 64'd0);
      check("restart_valid", 64'(k_valid), 64'd1);
      check("wr_start_data", 64'(k_data), 64'h77);
      k_ready = 1'b1;
      tick();
      check("restart_sent", 64'(k_valid), 64'd0);
      finish_kernel(32'h5555);

      // Reset after word 2 of 4; buffer must survive
      for (int i = 0; i < 4; i++) write_word(i, W'(32'hA1 + i));
      exp_w[0] = 32'hA1; exp_w[1] = 32'hA2; exp_w[2] = 32'hA3; exp_w[3] = 32'hA4;
      clear_q();
      k_ready = 1'b1;
      start_stream(4);
      tick(); tick();
      check("mid_word3_shown", 64'(k_data), 64'hA3);
      reset_n = 1'b0; k_ready = 1'b0;
      tick();
      check("mid_rst_valid", 64'(k_valid), 64'd0);
      check("mid_rst_first", 64'(k_first), 64'd0);
      check("mid_rst_last", 64'(k_last), 64'd0);
      check("mid_rst_data", 64'(k_data), 64'd0);
      check("mid_rst_result", 64'(result), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1; k_ready = 1'b1;
      repeat (3) tick();
      check("mid_rst_words", 64'(q_data.size()), 64'd2);
      check("mid_rst_idle_valid", 64'(k_valid), 64'd0);
      clear_q();
      start_stream(4);
      wait_stream(4);
      check_stream("rs", 4);
      finish_kernel(32'h0BADCAFE);
      check("rs_result", 64'(result), 64'h0BADCAFE);

      // k_done withheld in WAIT_DONE
      c0 = n_complete;
      start_stream(1);
      tick();
      repeat (7) tick();
      check("to_busy_7", 64'(busy), 64'd1);
      tick();
`ifdef HV_SENDER_TIMEOUT_EN
      check("to_busy_8", 64'(busy), 64'd0);
      check("to_error", 64'(error), 64'd1);
      check("to_no_complete", 64'(n_complete - c0), 64'd0);
      check("to_result_kept", 64'(result), 64'h0BADCAFE);
`else
      repeat (32) tick();
      check("nto_busy", 64'(busy), 64'd1);
      check("nto_error", 64'(error), 64'd0);
      finish_kernel(32'h600D);
      check("nto_result", 64'(result), 64'h600D);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
